// File: rtl/postproc_pkg.sv
// ---------------------------------------------------------------------------
// postproc_pkg
// Shared definitions for the disparity post-processing blocks.
//   DISP_WIDTH / WIN_SIZE / X_WIDTH : default pixel width, window size and
//                                     x-coordinate width.
//   ST_* : state encoding for the window reader FSM.
//   win_pix_idx : flat index of pixel (c,r) in a NUM_COL x NUM_COL window.
// ---------------------------------------------------------------------------
package postproc_pkg;

  localparam int DISP_WIDTH = 16;
  localparam int WIN_SIZE   = 5;
  localparam int X_WIDTH    = 11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  // Column c, line r lives at pixel slot c*num_col + r of the flat window.
  function automatic int win_pix_idx(input int c, input int r, input int num_col);
    return c * num_col + r;
  endfunction

endpackage

// File: rtl/win_col_shifter.sv
// ---------------------------------------------------------------------------
// win_col_shifter
// NUM_COL-column horizontal shift register holding the window under
// construction. Column 0 is the oldest; a shift drops column 0 and inserts
// the new column at NUM_COL-1.
//   clk, rst   : clock, asynchronous active-high reset
//   shift_i    : shift one column in this cycle
//   clr_i      : synchronous clear (wins over shift)
//   zero_i     : insert an all-zero column instead of col_i
//   col_i      : incoming column, line r at [r*WIDTH +: WIDTH]
//   shifted_o  : contents as they will be after a shift (combinational),
//                used by the parent to register the emitted window
// ---------------------------------------------------------------------------
module win_col_shifter
  import postproc_pkg::*;
#(
  parameter int WIDTH   = DISP_WIDTH,
  parameter int NUM_COL = WIN_SIZE
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             shift_i,
  input  logic                             clr_i,
  input  logic                             zero_i,
  input  logic [WIDTH*NUM_COL-1:0]         col_i,
  output logic [WIDTH*NUM_COL*NUM_COL-1:0] shifted_o
);

  // Distance between consecutive columns in the flat window vector.
  localparam int COL_W = win_pix_idx(1, 0, NUM_COL) * WIDTH;
  localparam int WIN_W = COL_W * NUM_COL;

  logic [WIN_W-1:0] cols_q;
  logic [COL_W-1:0] new_col;

  assign new_col   = zero_i ? '0 : col_i;
  assign shifted_o = {new_col, cols_q[WIN_W-1:COL_W]};

  // NOTE: the window storage is reset like any control register so the
  // left-border padding is zero even for the first line after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cols_q <= '0;
    end else if (clr_i) begin
      cols_q <= '0;
    end else if (shift_i) begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values.
      cols_q <= shifted_o;
    end
  end

endmodule

// File: rtl/disp_window_reader.sv
// ---------------------------------------------------------------------------
// disp_window_reader
// Consumes one vertical disparity column per accepted beat and emits one
// NUM_COL x NUM_COL window per image column, zero padded at both borders.
//   clk, rst   : clock, asynchronous active-high reset
//   clken      : global stall; all state holds when low
//   img_width  : pixels per line, latched on the first column of a line
//   col_in     : column, line r at [r*WIDTH +: WIDTH], r=0 is the top line
//   col_valid  : col_in valid
//   col_ready  : low while flushing the right border
//   win_out    : window, pixel (c,r) at [(c*NUM_COL+r)*WIDTH +: WIDTH]
//   win_valid  : win_out valid (qualified by clken downstream)
//   center_x   : x of window column c=R
//   line_end   : set with the last window of a line
// ---------------------------------------------------------------------------
module disp_window_reader
  import postproc_pkg::*;
#(
  parameter int WIDTH   = DISP_WIDTH,
  parameter int NUM_COL = WIN_SIZE,
  parameter int XWIDTH  = X_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clken,
  input  logic [XWIDTH-1:0]                img_width,
  input  logic [WIDTH*NUM_COL-1:0]         col_in,
  input  logic                             col_valid,
  output logic                             col_ready,
  output logic [WIDTH*NUM_COL*NUM_COL-1:0] win_out,
  output logic                             win_valid,
  output logic [XWIDTH-1:0]                center_x,
  output logic                             line_end
);

  localparam int WIN_W = WIDTH * NUM_COL * NUM_COL;
  localparam int R     = (NUM_COL - 1) / 2;

  localparam logic [XWIDTH-1:0] R_X    = XWIDTH'(R);
  localparam logic [XWIDTH-1:0] ONE_X  = XWIDTH'(1);
  localparam logic [XWIDTH-1:0] LAST_F = XWIDTH'(R - 1);

  logic [1:0]        state_q, state_d;
  logic [XWIDTH-1:0] x_q, x_d;      // index of the next column to accept
  logic [XWIDTH-1:0] w_q, w_d;      // latched line width
  logic [XWIDTH-1:0] f_q, f_d;      // flush step

  logic [WIN_W-1:0]  win_q;
  logic              valid_q;
  logic [XWIDTH-1:0] cx_q;
  logic              le_q;

  logic              accept;
  logic              shift_en;
  logic              shift_zero;
  logic              shift_clr;
  logic              emit;
  logic              emit_le;
  logic [XWIDTH-1:0] emit_cx;
  logic [WIN_W-1:0]  shifted;

  assign col_ready = (state_q != ST_FLUSH);
  assign accept    = clken & col_valid & col_ready;

  win_col_shifter #(
    .WIDTH   (WIDTH),
    .NUM_COL (NUM_COL)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .shift_i   (shift_en),
    .clr_i     (shift_clr),
    .zero_i    (shift_zero),
    .col_i     (col_in),
    .shifted_o (shifted)
  );

  always_comb begin
    // NOTE: every output of this block gets a default so no latch is inferred.
    state_d    = state_q;
    x_d        = x_q;
    w_d        = w_q;
    f_d        = f_q;
    shift_en   = 1'b0;
    shift_zero = 1'b0;
    shift_clr  = 1'b0;
    emit       = 1'b0;
    emit_le    = 1'b0;
    emit_cx    = '0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          w_d      = img_width;
          shift_en = 1'b1;
          x_d      = ONE_X;
          f_d      = '0;
          // A one-pixel line is already complete; go straight to flushing.
          state_d  = (img_width == ONE_X) ? ST_FLUSH : ST_FILL;
        end
      end

      ST_FILL: begin
        if (accept) begin
          shift_en = 1'b1;
          x_d      = x_q + ONE_X;
          if (x_q == R_X) begin
            emit    = 1'b1;
            emit_cx = '0;
            state_d = ST_RUN;
          end
          // Narrow lines (W <= R) end before the window fills; still terminate.
          if (x_q == w_q - ONE_X) begin
            f_d     = '0;
            state_d = ST_FLUSH;
          end
        end
      end

      ST_RUN: begin
        if (accept) begin
          shift_en = 1'b1;
          x_d      = x_q + ONE_X;
          emit     = 1'b1;
          emit_cx  = x_q - R_X;
          if (x_q == w_q - ONE_X) begin
            f_d     = '0;
            state_d = ST_FLUSH;
          end
        end
      end

      default: begin  // ST_FLUSH: shift zeros in for the right border
        if (clken) begin
          shift_en   = 1'b1;
          shift_zero = 1'b1;
          emit       = 1'b1;
          emit_cx    = w_q - R_X + f_q;
          f_d        = f_q + ONE_X;
          if (f_q == LAST_F) begin
            // The window is taken from the shifted value while the register
            // itself is cleared, ready for the next line's left padding.
            emit_le   = 1'b1;
            shift_clr = 1'b1;
            x_d       = '0;
            state_d   = ST_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      w_q     <= '0;
      f_q     <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      cx_q    <= '0;
      le_q    <= 1'b0;
    end else if (clken) begin
      state_q <= state_d;
      x_q     <= x_d;
      w_q     <= w_d;
      f_q     <= f_d;
      valid_q <= emit;
      le_q    <= emit_le;
      if (emit) begin
        win_q <= shifted;
        cx_q  <= emit_cx;
      end
    end
  end

  assign win_out   = win_q;
  assign win_valid = valid_q;
  assign center_x  = cx_q;
  assign line_end  = le_q;

endmodule

// File: tb/tb_disp_window_reader.sv
// ---------------------------------------------------------------------------
// tb_disp_window_reader
// Scoreboard bench: expected windows are pushed when a column is accepted and
// compared (content, centre, line_end, emitting clken-edge) when win_valid
// is observed.
// ---------------------------------------------------------------------------
module tb_disp_window_reader;

  localparam int WIDTH   = 16;
  localparam int NUM_COL = 5;
  localparam int XWIDTH  = 11;
  localparam int R       = (NUM_COL - 1) / 2;
  localparam int CW      = WIDTH * NUM_COL;
  localparam int TOT     = CW * NUM_COL;

  logic              clk;
  logic              rst;
  logic              clken;
  logic [XWIDTH-1:0] img_width;
  logic [CW-1:0]     col_in;
  logic              col_valid;
  logic              col_ready;
  logic [TOT-1:0]    win_out;
  logic              win_valid;
  logic [XWIDTH-1:0] center_x;
  logic              line_end;

  typedef struct {
    logic [TOT-1:0]    win;
    logic [XWIDTH-1:0] cx;
    logic              le;
    int                edge_n;
  } exp_t;

  exp_t          exp_q[$];
  logic [CW-1:0] line_cols [0:63];

  int errors;
  int checks;
  int edge_cnt;
  int win_cnt;
  int ready_low_cnt;

  disp_window_reader #(
    .WIDTH   (WIDTH),
    .NUM_COL (NUM_COL),
    .XWIDTH  (XWIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clken     (clken),
    .img_width (img_width),
    .col_in    (col_in),
    .col_valid (col_valid),
    .col_ready (col_ready),
    .win_out   (win_out),
    .win_valid (win_valid),
    .center_x  (center_x),
    .line_end  (line_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Index of the most recent clock edge on which the DUT was enabled.
  always @(posedge clk) begin
    if (clken && !rst) edge_cnt <= edge_cnt + 1;
  end

  function automatic logic [CW-1:0] col_word(input int mode, input int x);
    logic [CW-1:0] v;
    v = '0;
    for (int r = 0; r < NUM_COL; r++) begin
      if (mode == 0) v[r*WIDTH +: WIDTH] = WIDTH'(x + 1);
      else           v[r*WIDTH +: WIDTH] = WIDTH'(16'h0100 * r + x);
    end
    return v;
  endfunction

  function automatic logic [TOT-1:0] exp_win(input int cx, input int w);
    logic [TOT-1:0] v;
    int idx;
    v = '0;
    for (int c = 0; c < NUM_COL; c++) begin
      idx = cx - R + c;
      if (idx >= 0 && idx < w) v[c*CW +: CW] = line_cols[idx];
    end
    return v;
  endfunction

  // Monitor: pop and compare every window the DUT presents in an enabled cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && clken) begin
      if (!col_ready) ready_low_cnt++;
      if (win_valid) begin
        checks++;
        win_cnt++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_window: got center_x=%0d line_end=%0b, none expected",
                   center_x, line_end);
        end else begin
          e = exp_q.pop_front();
          if (win_out !== e.win || center_x !== e.cx || line_end !== e.le ||
              edge_cnt != e.edge_n) begin
            errors++;
            $display("FAIL window: got cx=%0d le=%0b edge=%0d win=%h | want cx=%0d le=%0b edge=%0d win=%h",
                     center_x, line_end, edge_cnt, win_out, e.cx, e.le, e.edge_n, e.win);
          end
        end
      end
    end
  end

  // Present one column, wait for acceptance, then record the windows it completes.
  task automatic drive_col(input int x, input int w);
    exp_t e;
    bit   acc;
    int   ae;
    col_in    = line_cols[x];
    col_valid = 1'b1;
    acc = 1'b0;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = clken && col_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: column x=%0d not accepted, required within 200 cycles", x);
      return;
    end
    ae = edge_cnt;
    if (x >= R) begin
      e.win = exp_win(x - R, w); e.cx = XWIDTH'(x - R);
      e.le = (x - R == w - 1); e.edge_n = ae;
      exp_q.push_back(e);
    end
    if (x == w - 1) begin
      for (int k = 0; k < R; k++) begin
        e.win = exp_win(w - R + k, w); e.cx = XWIDTH'(w - R + k);
        e.le = (k == R - 1); e.edge_n = ae + 1 + k;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic send_line(input int w, input int mode, input int gap_max,
                           input int stall_x, input int stop_x, input bit aaaa_first);
    logic [TOT-1:0]    snap_win;
    logic [XWIDTH-1:0] snap_cx;
    logic              snap_v;
    logic              snap_le;
    for (int x = 0; x < w; x++) line_cols[x] = col_word(mode, x);
    if (aaaa_first) line_cols[0] = {NUM_COL{16'hAAAA}};
    img_width = XWIDTH'(w);
    for (int x = 0; x < w; x++) begin
      if (gap_max > 0) begin
        int n;
        n = $urandom_range(gap_max, 0);
        col_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
      end
      drive_col(x, w);
      if (x == stall_x) begin
        clken     = 1'b0;
        col_valid = 1'b0;
        snap_win = win_out; snap_cx = center_x; snap_v = win_valid; snap_le = line_end;
        repeat (3) begin
          @(negedge clk);
          checks++;
          if (win_out !== snap_win || center_x !== snap_cx ||
              win_valid !== snap_v || line_end !== snap_le) begin
            errors++;
            $display("FAIL stall_hold: got cx=%0d v=%0b le=%0b, held cx=%0d v=%0b le=%0b",
                     center_x, win_valid, line_end, snap_cx, snap_v, snap_le);
          end
        end
        @(posedge clk);
        #1;
        clken = 1'b1;
      end
      if (x == stop_x) return;
    end
  endtask

  task automatic wait_drain(input string name, input int want_wins, input int want_low);
    col_valid = 1'b0;
    for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d windows still pending, required 0", name, exp_q.size());
    end
    exp_q.delete();
    checks++;
    if (win_cnt != want_wins) begin
      errors++;
      $display("FAIL %s_window_count: got %0d, required %0d", name, win_cnt, want_wins);
    end
    checks++;
    if (ready_low_cnt != want_low) begin
      errors++;
      $display("FAIL %s_ready_low_cycles: got %0d, required %0d", name, ready_low_cnt, want_low);
    end
    checks++;
    if (col_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_idle_ready: got %0b, required 1", name, col_ready);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if (win_out !== '0 || win_valid !== 1'b0 || center_x !== '0 ||
        line_end !== 1'b0 || col_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: got v=%0b cx=%0d le=%0b ready=%0b win_nonzero=%0b, required 0/0/0/1/0",
               name, win_valid, center_x, line_end, col_ready, (win_out != '0));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clken = 1'b1; col_valid = 1'b0; col_in = '0; img_width = '0;
    #2;
    check_outputs_zero("reset_state");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    win_cnt = 0; ready_low_cnt = 0;
    send_line(8, 0, 0, -1, -1, 1'b0);
    wait_drain("basic", 8, 2);
  endtask

  task automatic test_back_to_back();
    win_cnt = 0; ready_low_cnt = 0;
    send_line(8, 0, 0, -1, -1, 1'b0);
    send_line(8, 0, 0, -1, -1, 1'b0);
    wait_drain("back_to_back", 16, 4);
  endtask

  task automatic test_gaps_clken();
    win_cnt = 0; ready_low_cnt = 0;
    send_line(8, 1, 2, 4, -1, 1'b0);
    wait_drain("gaps_clken", 8, 2);
  endtask

  task automatic test_flush_hold();
    win_cnt = 0; ready_low_cnt = 0;
    send_line(8, 1, 0, -1, -1, 1'b0);
    send_line(8, 1, 0, -1, -1, 1'b1);
    wait_drain("flush_hold", 16, 4);
  endtask

  task automatic test_reset_mid_line();
    win_cnt = 0; ready_low_cnt = 0;
    send_line(8, 0, 0, -1, 4, 1'b0);
    rst       = 1'b1;
    col_valid = 1'b0;
    #1;
    check_outputs_zero("reset_mid_line");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    win_cnt = 0; ready_low_cnt = 0;
    send_line(6, 1, 0, -1, -1, 1'b0);
    wait_drain("after_reset", 6, 2);
  endtask

  initial begin
    errors = 0; checks = 0; edge_cnt = 0; win_cnt = 0; ready_low_cnt = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_gaps_clken();
    test_flush_hold();
    test_reset_mid_line();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
